// File: rtl/branch_issue_ctrl_pkg.sv
// Shared types for the branch issue controller: branch masks, broadcast tasks,
// issue packets and the controller state encoding.
package branch_issue_ctrl_pkg;

    typedef logic [3:0] BR_MASK;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        logic [7:0] tag;
        BR_MASK     b_mask;
    } ISSUE_PACKET;

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        SQUASH_WAIT
    } BR_ISSUE_STATE;

    function automatic logic mask_hit(input BR_MASK m, input BR_MASK id);
        return |(m & id);
    endfunction

endpackage

// File: rtl/branch_issue_ctrl_age_matrix.sv
// Exact DEPTH x DEPTH age matrix: older[i][j]=1 means entry i is older than entry j.
// Same-cycle inserts land in ascending slots in program order, so lower slot is older.
module br_age_matrix #(
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] ins,
    input  logic [DEPTH-1:0] free,
    input  logic [DEPTH-1:0] squash,
    output logic [DEPTH-1:0] oldest
);

    logic [DEPTH-1:0][DEPTH-1:0] older;

    always_ff @(posedge clock) begin
        if (reset) begin
            older <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (free[i] || squash[i] || free[j] || squash[j])
                        older[i][j] <= 1'b0;
                    else if (ins[i] && ins[j])
                        older[i][j] <= (i < j);
                    else if (ins[j])
                        older[i][j] <= valid[i];
                    else if (ins[i])
                        older[i][j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        oldest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++)
                blocked = blocked | (valid[j] & older[j][i]);
            oldest[i] = valid[i] & ~blocked;
        end
    end

endmodule

// File: rtl/branch_issue_ctrl.sv
// Oldest-first issue buffer feeding the single branch FU, tracking CLEAR/SQUASH broadcasts.
// Optional counters enabled by defining BRANCH_ISSUE_STATS_EN.
module branch_issue_ctrl
    import branch_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IN_W  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [IN_W-1:0]         in_valid,
    input  ISSUE_PACKET [IN_W-1:0]  in_pack,
    output logic                    in_ready,
    input  BR_TASK                  rem_br_task,
    input  BR_MASK                  rem_b_id,
    output ISSUE_PACKET             fu_pack,
    output logic                    fu_rd_en,
    output logic [$clog2(DEPTH):0]  occupancy
`ifdef BRANCH_ISSUE_STATS_EN
    ,
    output logic [31:0]             stat_issued,
    output logic [31:0]             stat_squashed,
    output logic [31:0]             stat_full
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    function automatic logic [CW-1:0] count_ones(input logic [DEPTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < DEPTH; i++)
            c = c + CW'(v[i]);
        return c;
    endfunction

    BR_ISSUE_STATE            state;
    logic [DEPTH-1:0]         valid, valid_nxt;
    ISSUE_PACKET [DEPTH-1:0]  ent, ent_nxt;
    logic [DEPTH-1:0]         oldest, free_vec, sq_vec, ins_vec;
    logic [IN_W-1:0]          lane_acc, lane_drop;
    logic [CW-1:0]            occ_nxt;
    logic                     is_squash, is_clear;

    assign is_squash = (rem_br_task == SQUASH);
    assign is_clear  = (rem_br_task == CLEAR);
    assign in_ready  = (CW'(DEPTH) - occupancy) >= CW'(IN_W);
    assign fu_rd_en  = !reset && (state == ACTIVE) && (|valid) && !is_squash;
    assign lane_acc  = in_valid & {IN_W{in_ready}};
    assign free_vec  = fu_rd_en ? oldest : '0;
    assign occ_nxt   = count_ones(valid_nxt);

    always_comb begin
        fu_pack = '0;
        for (int i = 0; i < DEPTH; i++)
            if (fu_rd_en && oldest[i])
                fu_pack = ent[i];
    end

    // Next buffer contents: broadcast effects on held entries, then lane placement
    // into free slots taken from registered validity only.
    always_comb begin
        int k;
        k         = 0;
        sq_vec    = '0;
        ins_vec   = '0;
        lane_drop = '0;
        ent_nxt   = ent;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && is_squash && mask_hit(ent[i].b_mask, rem_b_id))
                sq_vec[i] = 1'b1;
            if (is_clear)
                ent_nxt[i].b_mask = ent[i].b_mask & ~rem_b_id;
        end
        valid_nxt = valid & ~free_vec & ~sq_vec;
        for (int s = 0; s < DEPTH; s++) begin
            if (!valid[s] && k < IN_W) begin
                for (int l = 0; l < IN_W; l++) begin
                    if (l == k && lane_acc[l]) begin
                        if (is_squash && mask_hit(in_pack[l].b_mask, rem_b_id)) begin
                            lane_drop[l] = 1'b1;
                        end else begin
                            ins_vec[s]   = 1'b1;
                            valid_nxt[s] = 1'b1;
                            ent_nxt[s]   = in_pack[l];
                            if (is_clear)
                                ent_nxt[s].b_mask = in_pack[l].b_mask & ~rem_b_id;
                        end
                    end
                end
                k = k + 1;
            end
        end
    end

    br_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clock  (clock),
        .reset  (reset),
        .valid  (valid),
        .ins    (ins_vec),
        .free   (free_vec),
        .squash (sq_vec),
        .oldest (oldest)
    );

    always_ff @(posedge clock)
        ent <= ent_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid     <= '0;
            occupancy <= '0;
            state     <= EMPTY;
        end else begin
            valid     <= valid_nxt;
            occupancy <= occ_nxt;
            case (state)
                EMPTY:       if (occ_nxt != '0) state <= ACTIVE;
                ACTIVE: begin
                    if (is_squash)          state <= SQUASH_WAIT;
                    else if (occ_nxt == '0) state <= EMPTY;
                end
                SQUASH_WAIT: begin
                    if (is_squash)          state <= SQUASH_WAIT;
                    else if (occ_nxt != '0) state <= ACTIVE;
                    else                    state <= EMPTY;
                end
                default:                    state <= EMPTY;
            endcase
        end
    end

`ifdef BRANCH_ISSUE_STATS_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    logic [31:0] drop_cnt;
    always_comb begin
        drop_cnt = 32'(count_ones(sq_vec));
        for (int l = 0; l < IN_W; l++)
            drop_cnt = drop_cnt + 32'(lane_drop[l]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_issued   <= '0;
            stat_squashed <= '0;
            stat_full     <= '0;
        end else begin
            stat_issued   <= sat_add(stat_issued, 32'(fu_rd_en));
            stat_squashed <= sat_add(stat_squashed, drop_cnt);
            stat_full     <= sat_add(stat_full, 32'(!in_ready));
        end
    end
`endif

endmodule
